// File: rtl/fifo_stream_reader_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// fifo_stream_reader_pkg : shared constants and types for the reader
// Revision: 1.0
// ------------------------------------------------------------------
package fifo_stream_reader_pkg;

  localparam int c_DATA_WIDTH = 8;
  localparam int c_BUF_DEPTH  = 3;
  localparam int c_LEVEL_W    = 2;

  typedef logic [c_LEVEL_W-1:0] level_t;

  // Encoded as {push, pop} so the buffer can cast its qualified strobes directly.
  typedef enum logic [1:0] {
    BUF_HOLD = 2'b00,
    BUF_POP  = 2'b01,
    BUF_PUSH = 2'b10,
    BUF_SWAP = 2'b11
  } buf_op_e;

  function automatic logic has_credit(input level_t lvl, input logic infl, input int depth);
    logic [2:0] sum;
    sum = {1'b0, lvl} + {2'b00, infl};
    return sum < 3'(depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_stream_reader_if.sv
`default_nettype none
// ------------------------------------------------------------------
// fifo_stream_reader_if : FIFO read port plus output stream bundle
// Revision: 1.0
// ------------------------------------------------------------------
interface fifo_stream_reader_if
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = c_DATA_WIDTH
);
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_empty;
  logic                  flush;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  level_t                level;

  modport master (
    output fifo_rd_en, m_valid, m_data, level,
    input  fifo_dout, fifo_empty, flush, m_ready
  );

  modport slave (
    input  fifo_rd_en, m_valid, m_data, level,
    output fifo_dout, fifo_empty, flush, m_ready
  );
endinterface
`default_nettype wire

// File: rtl/fifo_stream_reader_stream_out_buf.sv
`default_nettype none
// ------------------------------------------------------------------
// stream_out_buf : small ordered register buffer, head at entry 0
// Revision: 1.0
// ------------------------------------------------------------------
module stream_out_buf
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = c_DATA_WIDTH,
  parameter int DEPTH      = c_BUF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  input  logic                  clear,
  output level_t                level,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] head
);
  localparam level_t c_FULL = level_t'(DEPTH);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] r_mem;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] w_mem_nxt;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] w_shift;
  level_t  r_level;
  level_t  w_level_nxt;
  level_t  w_level_popped;
  logic    r_valid;
  logic    w_pop_ok;
  logic    w_push_ok;
  buf_op_e w_op;

  assign w_pop_ok       = pop & (r_level != '0);
  assign w_level_popped = r_level - level_t'(w_pop_ok);
  assign w_push_ok      = push & (w_level_popped < c_FULL);
  assign w_op           = buf_op_e'({w_push_ok, w_pop_ok});

  always_comb begin
    w_shift = '0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      w_shift[i] = r_mem[i+1];
    end
  end

  always_comb begin
    w_mem_nxt   = r_mem;
    w_level_nxt = r_level;
    if (clear) begin
      w_mem_nxt   = '0;
      w_level_nxt = '0;
    end else begin
      case (w_op)
        BUF_HOLD: ;
        BUF_POP: begin
          w_mem_nxt   = w_shift;
          w_level_nxt = r_level - level_t'(1);
        end
        BUF_PUSH: begin
          w_mem_nxt[r_level] = din;
          w_level_nxt        = r_level + level_t'(1);
        end
        // Simultaneous pop and push: shift, then fill the slot the tail moved out of.
        BUF_SWAP: begin
          w_mem_nxt                        = w_shift;
          w_mem_nxt[r_level - level_t'(1)] = din;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem   <= '0;
      r_level <= '0;
      r_valid <= 1'b0;
    end else begin
      r_mem   <= w_mem_nxt;
      r_level <= w_level_nxt;
      r_valid <= (w_level_nxt != '0);
    end
  end

  assign level = r_level;
  assign valid = r_valid;
  assign head  = r_mem[0];

endmodule
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ------------------------------------------------------------------
// fifo_stream_reader : credit-based reader turning a sync FIFO into a stream
// Revision: 1.0
// ------------------------------------------------------------------
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = c_DATA_WIDTH,
  parameter int BUF_DEPTH  = c_BUF_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fifo_stream_reader_if.master bus
);
  logic                  r_inflight;
  logic                  w_rd_en;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_valid;
  level_t                w_level;
  logic [DATA_WIDTH-1:0] w_head;

  // Credit counts buffered words plus the one read whose data is still on its way.
  assign w_rd_en = rst_n & ~bus.fifo_empty & ~bus.flush
                 & has_credit(w_level, r_inflight, BUF_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
    end
  end

  assign w_push = r_inflight & ~bus.flush;
  assign w_pop  = w_valid & bus.m_ready & ~bus.flush;

  stream_out_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .din   (bus.fifo_dout),
    .pop   (w_pop),
    .clear (bus.flush),
    .level (w_level),
    .valid (w_valid),
    .head  (w_head)
  );

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.m_valid    = w_valid;
  assign bus.m_data     = w_head;
  assign bus.level      = w_level;

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// Testbench for fifo_stream_reader: queue-based reference model plus scenario pins.
module tb_fifo_stream_reader;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_stream_reader_if #(.DATA_WIDTH(8)) bus ();

  fifo_stream_reader #(
    .DATA_WIDTH (8),
    .BUF_DEPTH  (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Upstream synchronous FIFO: data appears the cycle after an accepted read.
  logic [7:0] wr_data [0:1023];
  int wr_cnt = 0;
  int rd_ptr = 0;
  assign bus.fifo_empty = (wr_cnt == rd_ptr);

  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      bus.fifo_dout <= wr_data[rd_ptr[9:0]];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  // Reference model: the buffer is a queue, one optional word in flight.
  logic [7:0] mq [$];
  logic       m_infl = 1'b0;
  logic [7:0] m_word = '0;
  int         m_rd   = 0;
  logic       m_go;
  logic       e_rd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_infl = 1'b0;
    end else begin
      m_go = !bus.fifo_empty && !bus.flush && (mq.size() + int'(m_infl) < 3);
      if (bus.flush) begin
        mq.delete();
      end else begin
        if (mq.size() != 0 && bus.m_ready) void'(mq.pop_front());
        if (m_infl) mq.push_back(m_word);
      end
      m_infl = m_go;
      if (m_go) begin
        m_word = wr_data[m_rd[9:0]];
        m_rd++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_rd_en", int'(bus.fifo_rd_en), 0);
      chk("rst_valid", int'(bus.m_valid), 0);
      chk("rst_data",  int'(bus.m_data), 0);
      chk("rst_level", int'(bus.level), 0);
    end else begin
      e_rd = !bus.fifo_empty && !bus.flush && (mq.size() + int'(m_infl) < 3);
      chk("rd_en", int'(bus.fifo_rd_en), int'(e_rd));
      chk("rd_while_empty", int'(bus.fifo_rd_en && bus.fifo_empty), 0);
      chk("m_valid", int'(bus.m_valid), int'(mq.size() != 0));
      chk("level", int'(bus.level), mq.size());
      if (mq.size() != 0) chk("m_data", int'(bus.m_data), int'(mq[0]));
    end
  end

  logic [7:0] got [0:63];
  int got_n, first_c, last_c;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic put(input logic [7:0] d);
    wr_data[wr_cnt[9:0]] = d;
    wr_cnt++;
  endtask

  // Records every word accepted downstream; toggle drives m_ready 0/1 alternately.
  task automatic collect(input int cycles, input bit toggle);
    got_n   = 0;
    first_c = -1;
    last_c  = -1;
    for (int c = 0; c < cycles; c++) begin
      if (toggle) bus.m_ready = c[0];
      @(negedge clk);
      if (bus.m_valid && bus.m_ready && got_n < 64) begin
        got[got_n] = bus.m_data;
        got_n++;
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      tick();
    end
  endtask

  task automatic chk_seq(input string nm, input int start, input int n);
    int errs;
    errs = 0;
    for (int j = 0; j < n && j < got_n; j++) begin
      if (got[j] != wr_data[start + j]) errs++;
    end
    chk(nm, errs, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    bus.m_ready = 1'b0;
    bus.flush   = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_level_pin", int'(bus.level), 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    // Latency from an idle reader
    bus.m_ready = 1'b1;
    put(8'hA5);
    #1 chk("lat_rd_en_n", int'(bus.fifo_rd_en), 1);
    @(negedge clk);
    chk("lat_valid_n", int'(bus.m_valid), 0);
    tick();
    @(negedge clk);
    chk("lat_valid_n1", int'(bus.m_valid), 0);
    tick();
    @(negedge clk);
    chk("lat_valid_n2", int'(bus.m_valid), 1);
    chk("lat_data_n2", int'(bus.m_data), 8'hA5);
    tick();
    tick();

    // Streaming throughput
    s = wr_cnt;
    for (int i = 1; i <= 14; i++) put(8'(i));
    collect(40, 1'b0);
    chk("thru_count", got_n, 14);
    chk("thru_span", last_c - first_c, 13);
    chk("thru_first", int'(got[0]), 8'h01);
    chk("thru_last", int'(got[13]), 8'h0E);
    chk_seq("thru_order", s, 14);

    // Backpressure
    bus.m_ready = 1'b0;
    s = wr_cnt;
    for (int i = 1; i <= 8; i++) put(8'(i));
    repeat (8) tick();
    @(negedge clk);
    chk("bp_level", int'(bus.level), 3);
    chk("bp_rd_en", int'(bus.fifo_rd_en), 0);
    chk("bp_head", int'(bus.m_data), 8'h01);
    tick();
    @(negedge clk);
    chk("bp_head_stable", int'(bus.m_data), 8'h01);
    tick();
    bus.m_ready = 1'b1;
    collect(20, 1'b0);
    chk("bp_count", got_n, 8);
    chk("bp_last", int'(got[7]), 8'h08);
    chk_seq("bp_order", s, 8);

    // Alternating ready
    s = wr_cnt;
    for (int i = 0; i < 16; i++) put(8'($urandom));
    collect(64, 1'b1);
    chk("alt_count", got_n, 16);
    chk_seq("alt_order", s, 16);

    // Flush with level=2 and one word in flight
    bus.m_ready = 1'b0;
    for (int i = 0; i < 6; i++) put(8'h31 + 8'(i));
    tick();
    tick();
    tick();
    #1 chk("fl_pre_level", int'(bus.level), 2);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    @(negedge clk);
    chk("fl_valid", int'(bus.m_valid), 0);
    chk("fl_level", int'(bus.level), 0);
    tick();
    bus.m_ready = 1'b1;
    collect(16, 1'b0);
    chk("fl_count", got_n, 3);
    chk("fl_next_word", int'(got[0]), 8'h34);

    // Reset in the middle of a stalled stream
    bus.m_ready = 1'b0;
    for (int i = 0; i < 8; i++) put(8'h50 + 8'(i));
    repeat (6) tick();
    #1 chk("rs_pre_level", int'(bus.level), 3);
    rst_n = 1'b0;
    #1;
    chk("rs_rd_en", int'(bus.fifo_rd_en), 0);
    chk("rs_valid", int'(bus.m_valid), 0);
    chk("rs_data", int'(bus.m_data), 0);
    chk("rs_level", int'(bus.level), 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1 chk("rs_resume_rd", int'(bus.fifo_rd_en), 1);
    tick();
    bus.m_ready = 1'b1;
    collect(20, 1'b0);
    chk("rs_count", got_n, 5);
    chk("rs_first", int'(got[0]), 8'h53);

    // Random traffic with occasional flushes
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 99) < 55) put(8'($urandom));
      bus.m_ready = 1'($urandom_range(0, 1));
      bus.flush   = ($urandom_range(0, 19) == 0);
      tick();
    end
    bus.flush   = 1'b0;
    bus.m_ready = 1'b1;
    repeat (20) tick();
    @(negedge clk);
    chk("final_drained", int'(bus.m_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
